// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl: multi-cycle Moore control unit for the MCPU datapath.
// The unit steps through fetch, decode, execute, memory and write-back
// states according to the instruction held in IR. It waits on MIO_ready for
// every memory access and for every PC update that completes an instruction.
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   MIO_ready       : memory handshake, 1 = access completes this cycle
//   opcode, funct   : inst[31:26] and inst[5:0] from IR
//   state           : current state code
//   IorD .. PCSrc   : datapath and memory-interface control strobes
module mcpu_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       MIO_ready,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [4:0] state,
   output logic       IorD,
   output logic       IRWrite,
   output logic       mem_w,
   output logic       CPU_MIO,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       RegWrite,
   output logic       ExtSel,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [3:0] ALUcontrol,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       Branch,
   output logic [1:0] PCSrc
);

   typedef enum logic [4:0] {
      S_IF       = 5'd0,
      S_ID       = 5'd1,
      S_MEM_ADDR = 5'd2,
      S_MEM_RD   = 5'd3,
      S_WB_LW    = 5'd4,
      S_MEM_WR   = 5'd5,
      S_R_EXE    = 5'd6,
      S_R_WB     = 5'd7,
      S_BEQ      = 5'd8,
      S_J        = 5'd9,
      S_I_EXE    = 5'd10,
      S_I_WB     = 5'd11,
      S_JAL      = 5'd12,
      S_ERR      = 5'd31
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_NOR = 6'b100111;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   state_t state_r;
   state_t state_nxt_s;

   assign state = state_r;

   // State register with synchronous reset to instruction fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IF;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and Moore output decode; every strobe defaults to 0.
   always_comb begin
      state_nxt_s = state_r;
      IorD        = 1'b0;
      IRWrite     = 1'b0;
      mem_w       = 1'b0;
      CPU_MIO     = 1'b0;
      RegDst      = 2'b00;
      MemtoReg    = 2'b00;
      RegWrite    = 1'b0;
      ExtSel      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUcontrol  = ALU_AND;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      Branch      = 1'b0;
      PCSrc       = 2'b00;

      case (state_r)
         S_IF: begin
            // Fetch and PC+4 share the cycle; IR only loads when data is valid.
            CPU_MIO    = 1'b1;
            IRWrite    = MIO_ready;
            ALUSrcB    = 2'b01;
            ALUcontrol = ALU_ADD;
            PCWrite    = 1'b1;
            if (MIO_ready) begin
               state_nxt_s = S_ID;
            end else begin
               state_nxt_s = S_IF;
            end
         end
         S_ID: begin
            // Branch target PC + (imm<<2) is precomputed into ALUOut here.
            ALUSrcB    = 2'b11;
            ALUcontrol = ALU_ADD;
            ExtSel     = 1'b1;
            case (opcode)
               OP_LW, OP_SW:                       state_nxt_s = S_MEM_ADDR;
               OP_RTYPE:                           state_nxt_s = S_R_EXE;
               OP_BEQ:                             state_nxt_s = S_BEQ;
               OP_J:                               state_nxt_s = S_J;
               OP_JAL:                             state_nxt_s = S_JAL;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  state_nxt_s = S_I_EXE;
               default:                            state_nxt_s = S_ERR;
            endcase
         end
         S_MEM_ADDR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ALUcontrol = ALU_ADD;
            ExtSel     = 1'b1;
            if (opcode == OP_LW) begin
               state_nxt_s = S_MEM_RD;
            end else begin
               state_nxt_s = S_MEM_WR;
            end
         end
         S_MEM_RD: begin
            CPU_MIO = 1'b1;
            IorD    = 1'b1;
            if (MIO_ready) begin
               state_nxt_s = S_WB_LW;
            end else begin
               state_nxt_s = S_MEM_RD;
            end
         end
         S_WB_LW: begin
            MemtoReg    = 2'b01;
            RegWrite    = 1'b1;
            state_nxt_s = S_IF;
         end
         S_MEM_WR: begin
            CPU_MIO = 1'b1;
            IorD    = 1'b1;
            mem_w   = 1'b1;
            if (MIO_ready) begin
               state_nxt_s = S_IF;
            end else begin
               state_nxt_s = S_MEM_WR;
            end
         end
         S_R_EXE: begin
            ALUSrcA     = 1'b1;
            state_nxt_s = S_R_WB;
            case (funct)
               FN_ADD:  ALUcontrol = ALU_ADD;
               FN_SUB:  ALUcontrol = ALU_SUB;
               FN_AND:  ALUcontrol = ALU_AND;
               FN_OR:   ALUcontrol = ALU_OR;
               FN_SLT:  ALUcontrol = ALU_SLT;
               FN_NOR:  ALUcontrol = ALU_NOR;
               default: state_nxt_s = S_ERR;
            endcase
         end
         S_R_WB: begin
            RegDst      = 2'b01;
            RegWrite    = 1'b1;
            state_nxt_s = S_IF;
         end
         S_BEQ: begin
            ALUSrcA     = 1'b1;
            ALUcontrol  = ALU_SUB;
            PCWriteCond = 1'b1;
            Branch      = 1'b1;
            PCSrc       = 2'b01;
            if (MIO_ready) begin
               state_nxt_s = S_IF;
            end else begin
               state_nxt_s = S_BEQ;
            end
         end
         S_J: begin
            PCWrite = 1'b1;
            PCSrc   = 2'b10;
            if (MIO_ready) begin
               state_nxt_s = S_IF;
            end else begin
               state_nxt_s = S_J;
            end
         end
         S_I_EXE: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = 2'b10;
            state_nxt_s = S_I_WB;
            case (opcode)
               OP_ADDI: begin ALUcontrol = ALU_ADD; ExtSel = 1'b1; end
               OP_SLTI: begin ALUcontrol = ALU_SLT; ExtSel = 1'b1; end
               OP_ANDI: begin ALUcontrol = ALU_AND; ExtSel = 1'b0; end
               OP_ORI:  begin ALUcontrol = ALU_OR;  ExtSel = 1'b0; end
               default: begin ALUcontrol = ALU_AND; ExtSel = 1'b0; end
            endcase
         end
         S_I_WB: begin
            RegWrite    = 1'b1;
            state_nxt_s = S_IF;
         end
         S_JAL: begin
            // Link value PC+4 was already written to PC during fetch.
            PCWrite  = 1'b1;
            PCSrc    = 2'b10;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
            RegWrite = MIO_ready;
            if (MIO_ready) begin
               state_nxt_s = S_IF;
            end else begin
               state_nxt_s = S_JAL;
            end
         end
         S_ERR: begin
            state_nxt_s = S_ERR;
         end
         default: begin
            state_nxt_s = S_ERR;
         end
      endcase
   end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb_mcpu_ctrl: directed self-checking bench for mcpu_ctrl.
module tb_mcpu_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       MIO_ready;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] state;
   logic       IorD, IRWrite, mem_w, CPU_MIO, RegWrite, ExtSel, ALUSrcA;
   logic       PCWrite, PCWriteCond, Branch;
   logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSrc;
   logic [3:0] ALUcontrol;

   int checks_r = 0;
   int errors_r = 0;

   mcpu_ctrl dut (
      .clk(clk), .reset(reset), .MIO_ready(MIO_ready),
      .opcode(opcode), .funct(funct), .state(state),
      .IorD(IorD), .IRWrite(IRWrite), .mem_w(mem_w), .CPU_MIO(CPU_MIO),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ExtSel(ExtSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUcontrol(ALUcontrol), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .Branch(Branch), .PCSrc(PCSrc)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks_r++;
      if (act !== exp) begin
         errors_r++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one clock and settle past the edge before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; MIO_ready = 1'b1; opcode = 6'd0; funct = 6'd0;
      step();
      // Reset / fetch values
      check_eq("rst_state", {27'd0, state}, 32'd0);
      check_eq("if_cpu_mio", {31'd0, CPU_MIO}, 32'd1);
      check_eq("if_irwrite_rdy", {31'd0, IRWrite}, 32'd1);
      check_eq("if_pcwrite", {31'd0, PCWrite}, 32'd1);
      check_eq("if_alusrcb", {30'd0, ALUSrcB}, 32'd1);
      check_eq("if_aluctl", {28'd0, ALUcontrol}, 32'h2);
      MIO_ready = 1'b0; #1;
      check_eq("if_irwrite_stall", {31'd0, IRWrite}, 32'd0);
      reset = 1'b0;
      step();
      check_eq("if_stall_state", {27'd0, state}, 32'd0);

      // lw: 0,1,2,3,4,0
      MIO_ready = 1'b1; opcode = 6'b100011;
      step();
      check_eq("lw_id", {27'd0, state}, 32'd1);
      check_eq("id_alusrcb", {30'd0, ALUSrcB}, 32'd3);
      check_eq("id_extsel", {31'd0, ExtSel}, 32'd1);
      step();
      check_eq("lw_maddr", {27'd0, state}, 32'd2);
      check_eq("maddr_srcs", {29'd0, ALUSrcA, ALUSrcB}, 32'b110);
      step();
      check_eq("lw_mrd", {27'd0, state}, 32'd3);
      check_eq("mrd_mio_iord", {30'd0, CPU_MIO, IorD}, 32'b11);
      step();
      check_eq("lw_wb", {27'd0, state}, 32'd4);
      check_eq("lw_wb_ctl", {27'd0, RegWrite, MemtoReg, RegDst}, 32'b10100);
      step();
      check_eq("lw_done", {27'd0, state}, 32'd0);

      // sw with three stalled cycles in MEM_WR
      opcode = 6'b101011;
      step(); step(); step();
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("sw_hold%0d", i), {27'd0, state}, 32'd5);
         check_eq($sformatf("sw_strb%0d", i), {29'd0, mem_w, IorD, CPU_MIO}, 32'b111);
         MIO_ready = (i == 3);
         #1;
         check_eq($sformatf("sw_strb_s%0d", i), {31'd0, mem_w}, 32'd1);
         step();
      end
      check_eq("sw_done", {27'd0, state}, 32'd0);

      // Reset in the middle of a stalled MEM_WR
      step(); step(); step();
      check_eq("sw2_state", {27'd0, state}, 32'd5);
      MIO_ready = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("rst_mid_state", {27'd0, state}, 32'd0);
      check_eq("rst_mid_memw", {31'd0, mem_w}, 32'd0);
      check_eq("rst_mid_mio_iord", {30'd0, CPU_MIO, IorD}, 32'b10);

      // R-type slt
      MIO_ready = 1'b1; opcode = 6'b000000; funct = 6'b101010;
      step(); step();
      check_eq("slt_exe", {27'd0, state}, 32'd6);
      check_eq("slt_aluctl", {28'd0, ALUcontrol}, 32'h7);
      check_eq("slt_srcs", {29'd0, ALUSrcA, ALUSrcB}, 32'b100);
      step();
      check_eq("slt_wb", {27'd0, state}, 32'd7);
      check_eq("slt_wb_ctl", {29'd0, RegWrite, RegDst}, 32'b101);
      step();
      check_eq("slt_done", {27'd0, state}, 32'd0);

      // R-type nor
      funct = 6'b100111;
      step(); step();
      check_eq("nor_aluctl", {28'd0, ALUcontrol}, 32'hC);
      step(); step();

      // andi and addi
      opcode = 6'b001100;
      step(); step();
      check_eq("andi_exe", {27'd0, state}, 32'd10);
      check_eq("andi_ext_alu", {27'd0, ExtSel, ALUcontrol}, 32'b00000);
      step();
      check_eq("andi_wb", {27'd0, state, RegWrite}, {26'd0, 5'd11, 1'b1});
      step();
      opcode = 6'b001000;
      step(); step();
      check_eq("addi_ext_alu", {27'd0, ExtSel, ALUcontrol}, 32'b10010);
      step(); step();

      // beq
      opcode = 6'b000100;
      step(); step();
      check_eq("beq_state", {27'd0, state}, 32'd8);
      check_eq("beq_ctl", {24'd0, ALUcontrol, PCWriteCond, Branch, PCSrc}, 32'b01101101);
      step();
      check_eq("beq_done", {27'd0, state}, 32'd0);

      // j
      opcode = 6'b000010;
      step(); step();
      check_eq("j_ctl", {24'd0, state, PCWrite, PCSrc}, {24'd0, 5'd9, 1'b1, 2'b10});
      step();
      check_eq("j_done", {27'd0, state}, 32'd0);

      // jal, with one stalled cycle
      opcode = 6'b000011;
      step(); step();
      check_eq("jal_state", {27'd0, state}, 32'd12);
      check_eq("jal_ctl", {25'd0, PCSrc, RegDst, MemtoReg, RegWrite}, 32'b1010101);
      MIO_ready = 1'b0; #1;
      check_eq("jal_regw_stall", {31'd0, RegWrite}, 32'd0);
      step();
      check_eq("jal_hold", {27'd0, state}, 32'd12);
      MIO_ready = 1'b1;
      step();
      check_eq("jal_done", {27'd0, state}, 32'd0);

      // Unknown opcode locks into ERR until reset
      opcode = 6'b111111;
      step(); step();
      check_eq("err_state", {27'd0, state}, 32'd31);
      step(); step();
      check_eq("err_hold", {27'd0, state}, 32'd31);
      check_eq("err_strb", {27'd0, PCWrite, CPU_MIO, mem_w, RegWrite, IRWrite}, 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("err_reset", {27'd0, state}, 32'd0);

      // Unknown funct goes to ERR from R_EXE
      opcode = 6'b000000; funct = 6'b111111;
      step(); step(); step();
      check_eq("badfn_err", {27'd0, state}, 32'd31);

      $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
      $finish;
   end

endmodule
